jk_pair_monitor: RTL and testbench

- Downstream checker for the dual-reset JK flip-flop pair (async-reset and sync-reset variants driven by common J/K/clk/reset).
- Consumes the J/K stimulus and both Q outputs, and runs an internal golden JK model.
- Counts Q toggles and mismatches, and flags a stuck toggle path and a fault condition.
- Sits beside the flip-flop pair in lab benches and board builds; its outputs drive LEDs and the scoreboard.

---
 rtl/jk_pair_monitor.sv | 155 +++++++++++++++
 tb/tb_jk_pair_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_pair_monitor.sv
// Checker for a dual-reset JK flip-flop pair: golden JK model, toggle/mismatch counters,
// stuck-toggle detection and a fault FSM. Define JKMON_ASYN_CHECK_EN to also compare q_asyn.
module jk_pair_monitor #(
    parameter int CNT_W        = 8,
    parameter int STUCK_LIMIT  = 16,
    parameter int FAULT_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             J,
    input  logic             K,
    input  logic             q_asyn,
    input  logic             q_syn,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             stuck,
    output logic             fault,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int RUN_W = $clog2(STUCK_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STUCK_LIMIT);

    state_t           state_reg, state_next;
    logic             gm_reg, gm_next;
    logic             q_prev_reg, q_prev_next;
    logic [CNT_W-1:0] toggle_cnt_reg, toggle_cnt_next;
    logic [CNT_W-1:0] mismatch_cnt_reg, mismatch_cnt_next;
    logic             stuck_reg, stuck_next;
    logic [RUN_W-1:0] stuck_run_reg, stuck_run_next;
    logic             fault_reg;

    logic mismatch;
    logic toggle;
    logic gm_jk;
    logic asyn_ok;

`ifdef JKMON_ASYN_CHECK_EN
    assign mismatch = (q_syn != gm_reg) | (q_asyn != q_syn);
    assign asyn_ok  = (q_asyn == q_syn);
`else
    logic unused_asyn;
    assign unused_asyn = q_asyn;
    assign mismatch    = (q_syn != gm_reg);
    assign asyn_ok     = 1'b1;
`endif

    assign toggle = (q_syn != q_prev_reg);

    // Golden JK next value from the sampled J/K.
    always_comb begin
        gm_jk = gm_reg;
        case ({J, K})
            2'b01:   gm_jk = 1'b0;
            2'b10:   gm_jk = 1'b1;
            2'b11:   gm_jk = ~gm_reg;
            default: gm_jk = gm_reg;
        endcase
    end

    always_comb begin
        state_next        = state_reg;
        gm_next           = gm_reg;
        q_prev_next       = q_prev_reg;
        toggle_cnt_next   = toggle_cnt_reg;
        mismatch_cnt_next = mismatch_cnt_reg;
        stuck_next        = stuck_reg;
        stuck_run_next    = stuck_run_reg;

        if (clear) begin
            state_next        = IDLE;
            toggle_cnt_next   = '0;
            mismatch_cnt_next = '0;
            stuck_next        = 1'b0;
            stuck_run_next    = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) state_next = SYNC;
                end
                SYNC: begin
                    // Align model and toggle history to the flip-flop before counting.
                    gm_next     = q_syn;
                    q_prev_next = q_syn;
                    if (asyn_ok) state_next = RUN;
                end
                RUN: begin
                    gm_next     = gm_jk;
                    q_prev_next = q_syn;
                    if (mismatch && (mismatch_cnt_reg != CNT_MAX))
                        mismatch_cnt_next = mismatch_cnt_reg + 1'b1;
                    if (toggle && (toggle_cnt_reg != CNT_MAX))
                        toggle_cnt_next = toggle_cnt_reg + 1'b1;
                    if (J && K && !toggle) begin
                        if (stuck_run_reg != RUN_LIMIT)
                            stuck_run_next = stuck_run_reg + 1'b1;
                    end else begin
                        stuck_run_next = '0;
                    end
                    if (stuck_run_next == RUN_LIMIT) stuck_next = 1'b1;
                    // Threshold takes priority over enable dropping on the same edge.
                    if (mismatch && (int'(mismatch_cnt_next) >= FAULT_THRESH))
                        state_next = FAULT;
                    else if (!enable)
                        state_next = IDLE;
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            gm_reg           <= 1'b0;
            q_prev_reg       <= 1'b0;
            toggle_cnt_reg   <= '0;
            mismatch_cnt_reg <= '0;
            stuck_reg        <= 1'b0;
            stuck_run_reg    <= '0;
            fault_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            gm_reg           <= gm_next;
            q_prev_reg       <= q_prev_next;
            toggle_cnt_reg   <= toggle_cnt_next;
            mismatch_cnt_reg <= mismatch_cnt_next;
            stuck_reg        <= stuck_next;
            stuck_run_reg    <= stuck_run_next;
            fault_reg        <= (state_next == FAULT);
        end
    end

    assign toggle_cnt   = toggle_cnt_reg;
    assign mismatch_cnt = mismatch_cnt_reg;
    assign stuck        = stuck_reg;
    assign fault        = fault_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_jk_pair_monitor.sv
// Randomized + directed bench for jk_pair_monitor against a behavioural model of the checker rules.
module tb_jk_pair_monitor;

    localparam int CW   = 4;
    localparam int SL   = 6;
    localparam int FT   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef JKMON_ASYN_CHECK_EN
    localparam bit ASYN = 1'b1;
`else
    localparam bit ASYN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          enable;
    logic          clear;
    logic          J;
    logic          K;
    logic          q_asyn;
    logic          q_syn;
    logic [CW-1:0] toggle_cnt;
    logic [CW-1:0] mismatch_cnt;
    logic          stuck;
    logic          fault;
    logic [1:0]    state;

    int errors = 0;
    int checks = 0;
    bit ff_q   = 1'b0;

    jk_pair_monitor #(.CNT_W(CW), .STUCK_LIMIT(SL), .FAULT_THRESH(FT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .J(J), .K(K), .q_asyn(q_asyn), .q_syn(q_syn),
        .toggle_cnt(toggle_cnt), .mismatch_cnt(mismatch_cnt),
        .stuck(stuck), .fault(fault), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit jk(input bit q, input bit j, input bit k);
        if (j && k) return ~q;
        if (j) return 1'b1;
        if (k) return 1'b0;
        return q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectations at a settled point (state, toggles, mismatches, stuck, fault).
    task automatic expect_all(input string tag, input int st, input int tc, input int mc,
                              input int sk, input int fl);
        check({tag, ".state"}, int'(state), st);
        if (tc >= 0) check({tag, ".toggle_cnt"}, int'(toggle_cnt), tc);
        check({tag, ".mismatch_cnt"}, int'(mismatch_cnt), mc);
        check({tag, ".stuck"}, int'(stuck), sk);
        check({tag, ".fault"}, int'(fault), fl);
        $display("point %s: state=%0d toggles=%0d mismatches=%0d stuck=%0d fault=%0d",
                 tag, state, toggle_cnt, mismatch_cnt, stuck, fault);
    endtask

    // One clock of stimulus; qmode 0 = ideal flip-flop, 1 = inverted, 2 = held low.
    task automatic step(input bit rst, input bit clr, input bit en, input bit j, input bit k,
                        input int qmode, input bit ainj);
        bit qs;
        case (qmode)
            0:       qs = ff_q;
            1:       qs = ~ff_q;
            default: qs = 1'b0;
        endcase
        reset  = rst;
        clear  = clr;
        enable = en;
        J      = j;
        K      = k;
        q_syn  = qs;
        q_asyn = qs ^ ainj;
        @(negedge clk);
        ff_q = rst ? 1'b0 : jk(ff_q, j, k);
    endtask

    // Behavioural model, updated from the inputs sampled at each rising edge.
    int m_state = 0, m_t = 0, m_m = 0, m_srun = 0;
    bit m_gm = 0, m_qp = 0, m_stuck = 0, m_valid = 0;

    initial begin
        bit mm, tg;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_state = 0; m_gm = 0; m_qp = 0; m_t = 0; m_m = 0;
                m_stuck = 0; m_srun = 0; m_valid = 1;
            end else if (clear) begin
                m_state = 0; m_t = 0; m_m = 0; m_stuck = 0; m_srun = 0;
            end else begin
                case (m_state)
                    0: if (enable) m_state = 1;
                    1: begin
                        m_gm = q_syn;
                        m_qp = q_syn;
                        m_state = (ASYN && (q_asyn != q_syn)) ? 1 : 2;
                    end
                    2: begin
                        mm = (q_syn != m_gm) || (ASYN && (q_asyn != q_syn));
                        tg = (q_syn != m_qp);
                        m_gm = jk(m_gm, J, K);
                        m_qp = q_syn;
                        if (mm && m_m < CMAX) m_m++;
                        if (tg && m_t < CMAX) m_t++;
                        if (J && K && !tg) m_srun = (m_srun < SL) ? m_srun + 1 : SL;
                        else m_srun = 0;
                        if (m_srun == SL) m_stuck = 1;
                        if (mm && m_m >= FT) m_state = 3;
                        else if (!enable) m_state = 0;
                    end
                    default: ;
                endcase
            end
            #1;
            if (m_valid) begin
                check("state", int'(state), m_state);
                check("toggle_cnt", int'(toggle_cnt), m_t);
                check("mismatch_cnt", int'(mismatch_cnt), m_m);
                check("stuck", int'(stuck), int'(m_stuck));
                check("fault", int'(fault), (m_state == 3) ? 1 : 0);
            end
        end
    end

    initial begin
        int prof;
        reset = 1'b1; clear = 1'b0; enable = 1'b0; J = 1'b0; K = 1'b0;
        q_syn = 1'b0; q_asyn = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0, 0);
        expect_all("reset", 0, 0, 0, 0, 0);

        repeat (4) step(0, 0, 1, 1, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0, 1, 0, 0);
        expect_all("set_then_reset", 2, 1, 0, 0, 0);

        repeat (10) step(0, 0, 1, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        expect_all("toggle_run", 2, 11, 0, 0, 0);

        step(0, 1, 1, 0, 0, 0, 0);
        expect_all("clear1", 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        repeat (7) step(0, 0, 1, 1, 1, 2, 0);
        expect_all("stuck_set", 2, 0, 3, 1, 0);
        step(0, 0, 0, 1, 1, 2, 0);
        expect_all("fault_beats_disable", 3, 0, 4, 1, 1);
        repeat (8) step(0, 0, 0, 1, 1, 2, 0);
        expect_all("fault_hold", 3, 0, 4, 1, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        expect_all("clear2", 0, 0, 0, 0, 0);

        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        expect_all("mismatch_then_idle", 0, 3, 3, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0, 1, 0);
        expect_all("idle_hold", 0, 3, 3, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 1, 0, 1, 0, 0);
        expect_all("realign", 2, 4, 3, 0, 0);

        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        repeat (20) step(0, 0, 1, 1, 1, 0, 0);
        expect_all("toggle_saturate", 2, CMAX, 0, 0, 0);
        step(1, 0, 1, 1, 1, 0, 0);
        expect_all("reset_mid_run", 0, 0, 0, 0, 0);

        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 1, 1, 0, 0, 1);
        repeat (2) step(0, 0, 1, 0, 0, 0, 0);
        expect_all("asyn_diff", 2, 1, ASYN ? 2 : 0, 0, 0);

        step(1, 0, 0, 0, 0, 0, 0);
        for (int blk = 0; blk < 75; blk++) begin
            prof = $urandom_range(0, 3);
            for (int c = 0; c < 40; c++) begin
                if (prof == 3)
                    step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                         $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
                         $urandom_range(0, 3) != 0, 2, $urandom_range(0, 19) == 0);
                else
                    step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                         $urandom_range(0, 15) != 0, 1'($urandom), 1'($urandom),
                         ($urandom_range(0, 19) == 0) ? 1 : 0, $urandom_range(0, 19) == 0);
            end
            $display("random block %0d profile %0d: state=%0d toggles=%0d mismatches=%0d",
                     blk, prof, state, toggle_cnt, mismatch_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
